// File: rtl/cdb_arbiter_pkg.sv
// Shared defines for the common data bus arbiter: ROB id width, requester count and slot indices.
// `ROB_WIDTH may be supplied by the build; it falls back to 4 bits otherwise.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

package cdb_arbiter_pkg;

    localparam int CDB_ROB_W   = `ROB_WIDTH;
    localparam int CDB_NUM_REQ = 3;

    localparam int CDB_ALU = 0;
    localparam int CDB_LSB = 1;
    localparam int CDB_BRU = 2;

    function automatic int cdb_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// One-hot grant picker: first holder with a valid entry, searching upward from ptr and wrapping.
module cdb_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] hold_valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && hold_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per result source, one registered broadcast per cycle.
// Define CDB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority LSB > BRU > ALU.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          clear_in,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*`ROB_WIDTH-1:0] req_rob_id,
    input  logic [NUM_REQ*32-1:0]         req_value,
    output logic                          cdb_valid,
    output logic [1:0]                    cdb_src,
    output logic [`ROB_WIDTH-1:0]         cdb_rob_id,
    output logic [31:0]                   cdb_value
);

    localparam int RW    = `ROB_WIDTH;
    localparam int PTR_W = cdb_ptr_w(NUM_REQ);

    logic [NUM_REQ-1:0] hold_valid;
    logic [RW-1:0]      hold_rob [NUM_REQ];
    logic [31:0]        hold_val [NUM_REQ];

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] xfer;
    logic [PTR_W-1:0]   pick_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [RW-1:0]      sel_rob;
    logic [31:0]        sel_val;
    logic               advance;

    assign advance = rdy_in && !clear_in;

`ifdef CDB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_nxt;

    assign ptr_nxt  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign pick_ptr = rr_ptr;

    // rr_ptr holds the slot where the next search begins; it only moves on a real grant.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr <= '0;
        end else if (advance && (|grant)) begin
            rr_ptr <= ptr_nxt;
        end
    end
`else
    assign pick_ptr = PTR_W'(CDB_LSB);
`endif

    cdb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .hold_valid (hold_valid),
        .ptr        (pick_ptr),
        .grant      (grant)
    );

    always_comb begin
        grant_idx = '0;
        sel_rob   = '0;
        sel_val   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                sel_rob   = hold_rob[i];
                sel_val   = hold_val[i];
            end
        end
    end

    // A granted holder drains this edge, so it can take a new result on the same edge.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_in && advance && (!hold_valid[i] || grant[i]);
        end
        xfer = req_valid & req_ready;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_rob[i] <= '0;
                hold_val[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear_in) begin
                hold_valid <= '0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (xfer[i]) begin
                        hold_valid[i] <= 1'b1;
                        hold_rob[i]   <= req_rob_id[i*RW +: RW];
                        hold_val[i]   <= req_value[i*32 +: 32];
                    end else if (grant[i]) begin
                        hold_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid  <= 1'b0;
            cdb_src    <= '0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                cdb_valid <= 1'b0;
            end else if (|grant) begin
                cdb_valid  <= 1'b1;
                cdb_src    <= 2'(grant_idx);
                cdb_rob_id <= sel_rob;
                cdb_value  <= sel_val;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a slot-level reference model of holders and grant order.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int RW = CDB_ROB_W;

    logic            clk_in   = 1'b0;
    logic            rst_in   = 1'b0;
    logic            rdy_in   = 1'b0;
    logic            clear_in = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*RW-1:0] req_rob_id = '0;
    logic [N*32-1:0] req_value  = '0;
    logic            cdb_valid;
    logic [1:0]      cdb_src;
    logic [RW-1:0]   cdb_rob_id;
    logic [31:0]     cdb_value;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_full [N];
    logic [RW-1:0] m_rob [N];
    logic [31:0] m_val [N];
    int          m_last;
    logic        m_cv;
    logic [1:0]  m_src;
    logic [RW-1:0] m_orob;
    logic [31:0] m_oval;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear_in   (clear_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rob_id (req_rob_id),
        .req_value  (req_value),
        .cdb_valid  (cdb_valid),
        .cdb_src    (cdb_src),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_rob[i]  = '0;
            m_val[i]  = '0;
        end
        m_last = N - 1;
        m_cv   = 1'b0;
        m_src  = '0;
        m_orob = '0;
        m_oval = '0;
    endtask

    // Which full holder the arbitration rule selects, or -1 if all are empty.
    function automatic int pick_ref();
`ifdef CDB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (m_full[i]) return i;
        end
`else
        int order [3];
        order = '{CDB_LSB, CDB_BRU, CDB_ALU};
        for (int k = 0; k < 3; k++) begin
            if (m_full[order[k]]) return order[k];
        end
`endif
        return -1;
    endfunction

    task automatic drive(input logic rdy, input logic clr, input logic [N-1:0] valid);
        rdy_in    = rdy;
        clear_in  = clr;
        req_valid = valid;
        for (int i = 0; i < N; i++) begin
            req_rob_id[i*RW +: RW] = RW'($urandom);
            req_value[i*32 +: 32]  = $urandom;
        end
    endtask

    // Called just after a falling edge with inputs driven; ends just after the next falling edge.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = pick_ref();
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = rst_in && rdy_in && !clear_in && (!m_full[i] || g == i);
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk_in);
        if (rst_in && rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < N; i++) m_full[i] = 1'b0;
                m_cv = 1'b0;
            end else begin
                m_cv = (g >= 0);
                if (g >= 0) begin
                    m_src     = 2'(g);
                    m_orob    = m_rob[g];
                    m_oval    = m_val[g];
                    m_full[g] = 1'b0;
                    m_last    = g;
                end
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && exp_rdy[i]) begin
                        m_full[i] = 1'b1;
                        m_rob[i]  = req_rob_id[i*RW +: RW];
                        m_val[i]  = req_value[i*32 +: 32];
                    end
                end
            end
        end
        @(negedge clk_in);
        chk("cdb_valid",  64'(cdb_valid),  64'(m_cv));
        chk("cdb_src",    64'(cdb_src),    64'(m_src));
        chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_orob));
        chk("cdb_value",  64'(cdb_value),  64'(m_oval));
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_in);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        chk("rst_cdb_value", 64'(cdb_value), 64'(0));
        rst_in = 1'b1;

        // idle after reset
        repeat (4) begin drive(1'b1, 1'b0, '0); cycle(); end

        // single ALU result: broadcast exactly one cycle after transfer
        drive(1'b1, 1'b0, 3'b001);
        req_rob_id[0 +: RW] = RW'(5);
        req_value[0 +: 32]  = 32'h1234;
        cycle();
        drive(1'b1, 1'b0, '0); cycle();
        chk("single_src",   64'(cdb_src),    64'(CDB_ALU));
        chk("single_value", 64'(cdb_value),  64'h1234);
        drive(1'b1, 1'b0, '0); cycle();

        // continuous contention from all requesters
        repeat (9) begin drive(1'b1, 1'b0, 3'b111); cycle(); end
        repeat (4) begin drive(1'b1, 1'b0, '0); cycle(); end

        // one result each at the same edge
        drive(1'b1, 1'b0, 3'b111); cycle();
        repeat (4) begin drive(1'b1, 1'b0, '0); cycle(); end

        // flush with LSB and BRU holders full, then a fresh ALU result
        drive(1'b1, 1'b0, 3'b110); cycle();
        drive(1'b1, 1'b1, 3'b111); cycle();
        drive(1'b1, 1'b0, 3'b001); cycle();
        repeat (2) begin drive(1'b1, 1'b0, '0); cycle(); end

        // clear while paused is ignored
        drive(1'b1, 1'b0, 3'b111); cycle();
        drive(1'b0, 1'b1, 3'b111); cycle();
        repeat (4) begin drive(1'b1, 1'b0, '0); cycle(); end

        // pause with holders full, then reset in the middle of the pause
        drive(1'b1, 1'b0, 3'b111); cycle();
        drive(1'b1, 1'b0, '0); cycle();
        repeat (4) begin drive(1'b0, 1'b0, 3'b111); cycle(); end
        #3 rst_in = 1'b0;
        #1;
        model_reset();
        chk("midrst_ready",  64'(req_ready),  64'(0));
        chk("midrst_valid",  64'(cdb_valid),  64'(0));
        chk("midrst_src",    64'(cdb_src),    64'(0));
        chk("midrst_rob_id", 64'(cdb_rob_id), 64'(0));
        chk("midrst_value",  64'(cdb_value),  64'(0));
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) begin drive(1'b1, 1'b0, '0); cycle(); end

        // randomized traffic with pauses and occasional flushes
        repeat (500) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 24) == 0), N'($urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning the number of result requesters, with fixed slot order 0=ALU/RS, 1=LSB, 2=BRU.
REQ-002 The block SHALL use `ROB_WIDTH from the shared defines for every ROB id field.
REQ-003 The block SHALL have these ports, one clock and one reset, reset asynchronous and active-low:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- rdy_in  in  1  pause when low
- clear_in  in  1  flush from ROB misprediction
- req_valid  in  NUM_REQ  requester result valid
- req_ready  out  NUM_REQ  holder can accept
- req_rob_id  in  NUM_REQ*`ROB_WIDTH  target ROB entry per requester
- req_value  in  NUM_REQ*32  result value per requester
- cdb_valid  out  1  broadcast valid, drives ROB/RS/LSB wakeup
- cdb_src  out  2  index of the granted requester
- cdb_rob_id  out  `ROB_WIDTH  broadcast ROB id
- cdb_value  out  32  broadcast value

Function
REQ-004 Each requester SHALL own one holding register (hold_valid, rob_id, value), and a transfer SHALL occur on a rising edge with rdy_in=1, clear_in=0, req_valid[i]=1 and req_ready[i]=1.
REQ-005 req_ready[i] SHALL be rdy_in && !clear_in && (!hold_valid[i] || grant[i]), with no combinational path from req_valid, req_rob_id or req_value.
REQ-006 grant SHALL be one-hot or zero, computed only from hold_valid and the priority state, and SHALL be nonzero whenever any hold_valid is set.
REQ-007 On an edge with rdy_in=1 and clear_in=0 and a grant to i, the block SHALL:
- register cdb_valid=1, cdb_src=i, and the rob_id/value of holder i;
- clear hold_valid[i], unless a same-edge transfer refills it.
REQ-008 On an edge with no grant, cdb_valid SHALL be 0; cdb_valid SHALL never be high for two cycles from one holder entry.
REQ-009 Latency SHALL be exactly one cycle from transfer to cdb_valid when there is no contention; throughput SHALL be one broadcast per cycle in aggregate and one per cycle per requester when uncontended.
REQ-010 A holder that has lost arbitration SHALL retain its contents unchanged until granted or cleared.
REQ-011 While rdy_in=0, all state and outputs SHALL hold, and req_ready SHALL be 0.
REQ-012 On an edge with clear_in=1 and rdy_in=1, the block SHALL:
- clear all hold_valid and cdb_valid;
- accept no transfer;
- leave the priority pointer unchanged.
REQ-013 clear_in=1 with rdy_in=0 SHALL have no effect.

Reset
REQ-014 Asserting rst_in low SHALL immediately clear all hold_valid and set the priority pointer to 0.
REQ-015 Asserting rst_in low SHALL immediately set cdb_valid=0, cdb_src=0, cdb_rob_id=0 and cdb_value=0; it takes effect mid-transfer, and pending results are discarded.
REQ-016 While rst_in is low, req_ready SHALL be 0.

Configuration
REQ-017 With CDB_ROUND_ROBIN_EN defined, the grant SHALL be round-robin:
- search starts at the slot after the last granted one, modulo NUM_REQ;
- the pointer updates only on a grant.
REQ-018 Without CDB_ROUND_ROBIN_EN, the grant SHALL be fixed priority LSB(1) > BRU(2) > ALU(0), and there SHALL be no pointer register.

Structure
REQ-019 `ROB_WIDTH, NUM_REQ default and the requester index constants (CDB_ALU, CDB_LSB, CDB_BRU) SHALL live in the shared defines package.
REQ-020 Grant selection SHALL be a sub-module cdb_rr_pick (hold_valid, pointer -> one-hot grant); the fixed-priority build SHALL tie its pointer to 1.

Verification
REQ-021 Reset/idle: release rst_in with no requests -> cdb_valid=0 and req_ready=3'b111 every cycle.
REQ-022 Single request: ALU presents rob_id=5, value=0x1234 at edge N -> cdb_valid=1, src=0, rob_id=5, value=0x1234 at edge N+1 only.
REQ-023 Contention with round-robin: all three valid every cycle with distinct values -> grants in order 0,1,2,0,1,2; each requester sees req_ready=1 once per 3 cycles; no value is lost or duplicated.
REQ-024 Contention with fixed priority: all three requesters present one result each at the same edge -> broadcasts LSB, BRU, ALU on consecutive cycles.
REQ-025 Flush: LSB and BRU holders full, clear_in=1 for one cycle -> cdb_valid=0 on the next edge, the holders are empty, and a new ALU request is broadcast one cycle later.
REQ-026 Pause and reset: rdy_in=0 for 4 cycles with holders full -> outputs frozen and req_ready=0; then rst_in low mid-pause -> all outputs 0 immediately.
